// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - runtime-programmable clock divider with square wave, tick and glitch-free divisor update
module prog_clock_divider #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk_in_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             clr_i,
  input  logic             div_load_i,
  input  logic [CNT_W-1:0] div_value_i,
  output logic             slow_clk_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] div_active_o,
  output logic             upd_pending_o
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             slow_q, slow_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] next_div;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hi_len;
  logic             wrap;

  always_comb begin
    load_val = (div_value_i < DIV_MIN) ? DIV_MIN : div_value_i;
    // A load coinciding with a boundary beats an older pending value
    next_div = div_load_i ? load_val : (pend_vld_q ? pend_q : div_q);
    cnt_inc  = cnt_q + 1'b1;
    // ceil(N/2) computed without the N+1 overflow at N = 2**CNT_W-1
    hi_len   = (div_q >> 1) + {{(CNT_W-1){1'b0}}, div_q[0]};
    wrap     = enable_i && !clr_i && (cnt_q == div_q - 1'b1);

    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    slow_d     = slow_q;
    tick_d     = 1'b0;

    if (clr_i) begin
      div_d      = next_div;
      cnt_d      = next_div - 1'b1;
      pend_vld_d = 1'b0;
      slow_d     = 1'b0;
    end else if (wrap) begin
      div_d      = next_div;
      cnt_d      = '0;
      pend_vld_d = 1'b0;
      slow_d     = 1'b1;
      tick_d     = 1'b1;
    end else begin
      if (enable_i) begin
        cnt_d  = cnt_inc;
        slow_d = (cnt_inc < hi_len);
      end
      if (div_load_i) begin
        pend_d     = load_val;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q      <= DIV_RST - 1'b1;
      div_q      <= DIV_RST;
      pend_q     <= DIV_RST;
      pend_vld_q <= 1'b0;
      slow_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      slow_q     <= slow_d;
      tick_q     <= tick_d;
    end
  end

  assign slow_clk_o    = slow_q;
  assign tick_o        = tick_q;
  assign div_active_o  = div_q;
  assign upd_pending_o = pend_vld_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb/tb_prog_clock_divider.sv - self-checking bench for prog_clock_divider
module tb_prog_clock_divider;

  logic        clk = 1'b0;
  logic        rst, en, clr, ld;
  logic [15:0] val;
  logic        slow, tick, upd;
  logic [15:0] div_act;

  logic        en_s;
  logic        slow_s, tick_s, upd_s;
  logic [3:0]  div_s;

  int checks = 0;
  int errors = 0;

  int   m_n, m_pos, m_pend;
  logic m_slow, m_tick;

  bit s_on = 0;
  int s_k  = 0;

  always #5 clk = ~clk;

  prog_clock_divider #(.CNT_W(16), .DEFAULT_DIV(10)) dut (
    .clk_in_i(clk), .reset_i(rst), .enable_i(en), .clr_i(clr),
    .div_load_i(ld), .div_value_i(val),
    .slow_clk_o(slow), .tick_o(tick), .div_active_o(div_act), .upd_pending_o(upd)
  );

  // Narrow instance exercising the maximum ratio 2**CNT_W-1
  prog_clock_divider #(.CNT_W(4), .DEFAULT_DIV(15)) dut_s (
    .clk_in_i(clk), .reset_i(rst), .enable_i(en_s), .clr_i(1'b0),
    .div_load_i(1'b0), .div_value_i(4'd0),
    .slow_clk_o(slow_s), .tick_o(tick_s), .div_active_o(div_s), .upd_pending_o(upd_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 10; m_pos = 9; m_pend = -1; m_slow = 1'b0; m_tick = 1'b0;
  endtask

  // Period-position model: pos counts clk_in cycles into the current period
  task automatic model_step(input bit e, input bit c, input bit l, input int v);
    int cv;
    cv = (v < 2) ? 2 : v;
    if (c) begin
      m_n    = l ? cv : ((m_pend >= 0) ? m_pend : m_n);
      m_pend = -1;
      m_pos  = m_n - 1;
      m_slow = 1'b0;
      m_tick = 1'b0;
    end else if (e) begin
      if (m_pos == m_n - 1) begin
        m_n    = l ? cv : ((m_pend >= 0) ? m_pend : m_n);
        m_pend = -1;
        m_pos  = 0;
      end else begin
        m_pos = m_pos + 1;
        if (l) m_pend = cv;
      end
      m_slow = (m_pos < (m_n + 1) / 2);
      m_tick = (m_pos == 0);
    end else begin
      m_tick = 1'b0;
      if (l) m_pend = cv;
    end
  endtask

  task automatic cycle(input string tag);
    int p;
    @(posedge clk);
    #1;
    model_step(en, clr, ld, int'(val));
    chk({tag, ".slow"}, {31'd0, slow}, {31'd0, m_slow});
    chk({tag, ".tick"}, {31'd0, tick}, {31'd0, m_tick});
    chk({tag, ".div"}, {16'd0, div_act}, m_n);
    chk({tag, ".upd"}, {31'd0, upd}, {31'd0, (m_pend >= 0)});
    if (s_on) begin
      s_k++;
      p = (s_k - 1) % 15;
      chk("max.slow", {31'd0, slow_s}, {31'd0, (p < 8)});
      chk("max.tick", {31'd0, tick_s}, {31'd0, (p == 0)});
    end
    ld = 1'b0;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic run_to_pos(input string tag, input int p);
    for (int i = 0; i < 400 && m_pos != p; i++) cycle(tag);
    if (m_pos != p) begin
      checks++;
      errors++;
      $error("FAIL %s.align observed pos %0d expected %0d", tag, m_pos, p);
    end
  endtask

  initial begin
    int nticks, nhigh;
    rst = 1'b1; en = 1'b0; clr = 1'b0; ld = 1'b0; val = '0; en_s = 1'b0;
    model_reset();
    #12;
    chk("rst.slow", {31'd0, slow}, 32'd0);
    chk("rst.tick", {31'd0, tick}, 32'd0);
    chk("rst.div", {16'd0, div_act}, 32'd10);
    chk("rst.upd", {31'd0, upd}, 32'd0);
    chk("rst.div_max", {28'd0, div_s}, 32'd15);
    @(negedge clk);
    rst = 1'b0;
    run("idle", 2);

    // T1: default ratio 10 and max ratio 15 on the narrow instance
    en = 1'b1; en_s = 1'b1; s_on = 1;
    cycle("t1");
    chk("t1.first_tick", {31'd0, tick}, 32'd1);
    nticks = 1; nhigh = 1;
    for (int i = 0; i < 19; i++) begin
      cycle("t1");
      nticks += int'(tick);
      nhigh  += int'(slow);
    end
    chk("t1.ticks_in_20", nticks, 32'd2);
    chk("t1.high_in_20", nhigh, 32'd10);
    run("t1", 12);
    en_s = 1'b0; s_on = 0;

    // T2: divide by 7
    val = 16'd7; ld = 1'b1;
    cycle("t2");
    run("t2", 24);
    chk("t2.div7", {16'd0, div_act}, 32'd7);

    // T3: load 4 mid-period of N=10, then clamped loads
    val = 16'd10; ld = 1'b1;
    cycle("t3");
    run_to_pos("t3", 0);
    run_to_pos("t3", 3);
    val = 16'd4; ld = 1'b1;
    run("t3", 20);
    val = 16'd0; ld = 1'b1;
    run("t3", 6);
    chk("t3.clamp0", {16'd0, div_act}, 32'd2);
    val = 16'd1; ld = 1'b1;
    run("t3", 6);

    // T4: freeze mid-period, then clr in high phase
    val = 16'd10; ld = 1'b1;
    cycle("t4");
    run_to_pos("t4", 0);
    run_to_pos("t4", 2);
    en = 1'b0;
    run("t4", 3);
    en = 1'b1;
    run("t4", 15);
    run_to_pos("t4", 1);
    clr = 1'b1;
    cycle("t4");
    clr = 1'b0;
    chk("t4.clr_slow", {31'd0, slow}, 32'd0);
    run("t4", 5);

    // T5: load on the wrap edge, then load with clr
    run_to_pos("t5", m_n - 1);
    val = 16'd5; ld = 1'b1;
    cycle("t5");
    chk("t5.bypass_div", {16'd0, div_act}, 32'd5);
    run("t5", 8);
    clr = 1'b1; val = 16'd9; ld = 1'b1;
    cycle("t5");
    clr = 1'b0;
    chk("t5.clr_div", {16'd0, div_act}, 32'd9);
    run("t5", 12);

    // T6: async reset in the high phase, between edges
    val = 16'd6; ld = 1'b1;
    cycle("t6");
    run_to_pos("t6", 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6.slow", {31'd0, slow}, 32'd0);
    chk("t6.div", {16'd0, div_act}, 32'd10);
    chk("t6.upd", {31'd0, upd}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle("t6");
    chk("t6.first_tick", {31'd0, tick}, 32'd1);
    run("t6", 21);

    // Randomized operation against the model
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(0, 99) < 85);
      clr = ($urandom_range(0, 99) < 3);
      ld  = ($urandom_range(0, 99) < 8);
      val = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(14, 60)) : 16'($urandom_range(0, 13));
      cycle("rand");
    end
    clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
